// File: rtl/pacman_motion_unit.sv
// Pac-Man motion unit: button-to-heading decode, lane-grid legality check and
// position stepping on move_tick, with registered position and heading.
module pacman_motion_unit #(
  parameter int SPEED = 2,
  parameter int LANE  = 16,
  parameter int X_MIN = 40,
  parameter int X_MAX = 600,
  parameter int Y_MIN = 10,
  parameter int Y_MAX = 458,
  parameter int INI_X = 360,
  parameter int INI_Y = 154
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       l_button,
  input  logic       r_button,
  input  logic       u_button,
  input  logic       d_button,
  output logic [9:0] pm_xpos,
  output logic [9:0] pm_ypos,
  output logic [3:0] pm_direction,
  output logic [3:0] legal_moves
);

  localparam logic [3:0] DIR_IDLE = 4'b0000;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_D    = 4'b1000;

  localparam logic [9:0]  SPEED_P = 10'(SPEED);
  localparam logic [9:0]  INI_X_P = 10'(INI_X);
  localparam logic [9:0]  INI_Y_P = 10'(INI_Y);
  localparam logic [10:0] SPEED_W = 11'(SPEED);
  localparam logic [10:0] LANE_W  = 11'(LANE);
  localparam logic [10:0] X_MIN_W = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

  logic [9:0]  xpos_q, xpos_d;
  logic [9:0]  ypos_q, ypos_d;
  logic [3:0]  dir_q, dir_d;
  logic [3:0]  req_s;
  logic [3:0]  legal_s;
  logic [10:0] x_w_s, y_w_s, x_off_s, y_off_s;
  logic        x_lane_s, y_lane_s;

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [3:0] dir);
    case (dir)
      DIR_L:   step_x = x - SPEED_P;
      DIR_R:   step_x = x + SPEED_P;
      default: step_x = x;
    endcase
  endfunction

  function automatic logic [9:0] step_y(input logic [9:0] y, input logic [3:0] dir);
    case (dir)
      DIR_U:   step_y = y - SPEED_P;
      DIR_D:   step_y = y + SPEED_P;
      default: step_y = y;
    endcase
  endfunction

  // Legality flags; 11-bit bound compares keep edge positions from wrapping.
  always_comb begin
    x_w_s    = {1'b0, xpos_q};
    y_w_s    = {1'b0, ypos_q};
    x_off_s  = x_w_s - X_MIN_W;
    y_off_s  = y_w_s - Y_MIN_W;
    x_lane_s = ((x_off_s % LANE_W) == 11'd0);
    y_lane_s = ((y_off_s % LANE_W) == 11'd0);
    legal_s  = 4'b0000;
    legal_s[0] = y_lane_s && (x_w_s >= (X_MIN_W + SPEED_W));
    legal_s[1] = y_lane_s && ((x_w_s + SPEED_W) <= X_MAX_W);
    legal_s[2] = x_lane_s && (y_w_s >= (Y_MIN_W + SPEED_W));
    legal_s[3] = x_lane_s && ((y_w_s + SPEED_W) <= Y_MAX_W);
  end

  // Fixed-priority button decode: left > right > up > down.
  always_comb begin
    if (l_button) begin
      req_s = DIR_L;
    end else if (r_button) begin
      req_s = DIR_R;
    end else if (u_button) begin
      req_s = DIR_U;
    end else if (d_button) begin
      req_s = DIR_D;
    end else begin
      req_s = DIR_IDLE;
    end
  end

  // Next state: a legal request turns and steps; otherwise keep going if
  // possible; a blocked heading is kept so the sprite still faces the wall.
  always_comb begin
    dir_d  = dir_q;
    xpos_d = xpos_q;
    ypos_d = ypos_q;
    if (move_tick) begin
      if ((req_s != DIR_IDLE) && ((req_s & legal_s) != 4'b0000)) begin
        dir_d  = req_s;
        xpos_d = step_x(xpos_q, req_s);
        ypos_d = step_y(ypos_q, req_s);
      end else if ((dir_q != DIR_IDLE) && ((dir_q & legal_s) != 4'b0000)) begin
        xpos_d = step_x(xpos_q, dir_q);
        ypos_d = step_y(ypos_q, dir_q);
      end else begin
        dir_d = dir_q;
      end
    end else begin
      dir_d = dir_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      xpos_q <= INI_X_P;
      ypos_q <= INI_Y_P;
      dir_q  <= DIR_IDLE;
    end else begin
      xpos_q <= xpos_d;
      ypos_q <= ypos_d;
      dir_q  <= dir_d;
    end
  end

  assign pm_xpos      = xpos_q;
  assign pm_ypos      = ypos_q;
  assign pm_direction = dir_q;
  assign legal_moves  = legal_s;

endmodule

// File: tb/tb_pacman_motion_unit.sv
// Bench for pacman_motion_unit: directed scenarios plus random button/tick
// traffic compared against an arithmetic model of the sprite's motion rules.
module tb_pacman_motion_unit;
  localparam int SPEED = 2;
  localparam int LANE  = 16;
  localparam int X_MIN = 40;
  localparam int X_MAX = 600;
  localparam int Y_MIN = 10;
  localparam int Y_MAX = 458;
  localparam int INI_X = 360;
  localparam int INI_Y = 154;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_tick = 1'b0;
  logic       l_button = 1'b0, r_button = 1'b0, u_button = 1'b0, d_button = 1'b0;
  logic [9:0] pm_xpos, pm_ypos;
  logic [3:0] pm_direction, legal_moves;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: position in pixels and heading index (-1 = idle)
  int mx = INI_X;
  int my = INI_Y;
  int mh = -1;
  int dx[4] = '{-SPEED, SPEED, 0, 0};
  int dy[4] = '{0, 0, -SPEED, SPEED};

  pacman_motion_unit dut (
    .clk(clk), .rst(rst), .move_tick(move_tick),
    .l_button(l_button), .r_button(r_button), .u_button(u_button), .d_button(d_button),
    .pm_xpos(pm_xpos), .pm_ypos(pm_ypos), .pm_direction(pm_direction), .legal_moves(legal_moves)
  );

  always #5 clk = ~clk;

  function automatic bit can_go(int x, int y, int h);
    bit on_row = (((y - Y_MIN) % LANE) == 0);
    bit on_col = (((x - X_MIN) % LANE) == 0);
    int nx = x + dx[h];
    int ny = y + dy[h];
    if (h < 2) return on_row && nx >= X_MIN && nx <= X_MAX;
    return on_col && ny >= Y_MIN && ny <= Y_MAX;
  endfunction

  function automatic logic [3:0] ref_legal(int x, int y);
    logic [3:0] v;
    for (int h = 0; h < 4; h++) v[h] = can_go(x, y, h);
    return v;
  endfunction

  function automatic logic [3:0] ref_dir();
    logic [3:0] v;
    v = 4'b0000;
    if (mh >= 0) v[mh] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one clock: drive inputs, advance model at the edge, compare after the edge
  task automatic cyc(input logic r, input logic t, input logic l, input logic rr,
                     input logic u, input logic d);
    int req;
    rst = r; move_tick = t; l_button = l; r_button = rr; u_button = u; d_button = d;
    @(posedge clk);
    req = l ? 0 : rr ? 1 : u ? 2 : d ? 3 : -1;
    if (!r) begin
      mx = INI_X; my = INI_Y; mh = -1;
    end else if (t) begin
      if (req >= 0 && can_go(mx, my, req)) begin
        mh = req; mx += dx[mh]; my += dy[mh];
      end else if (mh >= 0 && can_go(mx, my, mh)) begin
        mx += dx[mh]; my += dy[mh];
      end
    end
    #1;
    chk("model_x", 16'(pm_xpos), 16'(mx));
    chk("model_y", 16'(pm_ypos), 16'(my));
    chk("model_dir", 16'(pm_direction), 16'(ref_dir()));
    chk("model_legal", 16'(legal_moves), 16'(ref_legal(mx, my)));
  endtask

  task automatic expect_state(input string tag, input int x, input int y,
                              input logic [3:0] dir, input logic [3:0] lg);
    chk({tag, "_x"}, 16'(pm_xpos), 16'(x));
    chk({tag, "_y"}, 16'(pm_ypos), 16'(y));
    chk({tag, "_dir"}, 16'(pm_direction), 16'(dir));
    chk({tag, "_legal"}, 16'(legal_moves), 16'(lg));
  endtask

  initial begin
    // reset
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_state("reset", 360, 154, 4'b0000, 4'b1111);
    // basic move then coasting
    cyc(1, 1, 1, 0, 0, 0);
    expect_state("left1", 358, 154, 4'b0001, 4'b0011);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0);
    expect_state("coast", 352, 154, 4'b0001, 4'b0011);
    // illegal turn is discarded
    cyc(1, 1, 0, 0, 1, 0);
    expect_state("illegal_up", 350, 154, 4'b0001, 4'b0011);
    // priority left over up
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0);
    expect_state("prio", 358, 154, 4'b0001, 4'b0011);
    // vertical move
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    expect_state("up2", 360, 150, 4'b0100, 4'b1100);
    // boundary stop at the left wall
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 160; i++) cyc(1, 1, 1, 0, 0, 0);
    expect_state("wall", 40, 154, 4'b0001, 4'b1110);
    cyc(1, 1, 1, 0, 0, 0);
    expect_state("wall_hold", 40, 154, 4'b0001, 4'b1110);
    cyc(1, 1, 0, 1, 0, 0);
    expect_state("reverse", 42, 154, 4'b0010, 4'b0011);
    // tick gating
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);
    expect_state("gated", 42, 154, 4'b0010, 4'b0011);
    // reset wins over a tick and a button
    cyc(0, 1, 0, 1, 0, 0);
    expect_state("mid_reset", 360, 154, 4'b0000, 4'b1111);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
